// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable multi-channel clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int DIV_MIN = 2;
    localparam int DIV_RST = 2;
    localparam int HI_RST  = 1;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: run/stop FSM, period counter, active and pending divisor/high-count.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clkin,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic         sync,
    input  logic [W-1:0] divisor,
    input  logic [W-1:0] high_cnt,
    output logic         clkout,
    output logic         tick,
    output logic         busy
);

    localparam logic [W-1:0] DMIN = W'(DIV_MIN);

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] pdiv_q, pdiv_d;
    logic [W-1:0] phi_q, phi_d;
    logic         pend_v_q, pend_v_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;

    logic [W-1:0] div_in, cnt_inc, nxt_div, nxt_hi;
    logic         boundary, restart;

    assign div_in   = (divisor < DMIN) ? DMIN : divisor;
    assign cnt_inc  = cnt_q + 1'b1;
    assign boundary = (state_q != IDLE) && (cnt_q == div_q - 1'b1);
    assign restart  = (state_q != IDLE) && (boundary || sync);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        hi_d     = hi_q;
        pdiv_d   = pdiv_q;
        phi_d    = phi_q;
        pend_v_d = pend_v_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        nxt_div  = div_q;
        nxt_hi   = hi_q;

        // A load landing on a restart cycle bypasses pending and governs the next period.
        if (load) begin
            nxt_div = div_in;
            nxt_hi  = high_cnt;
        end else if (pend_v_q) begin
            nxt_div = pdiv_q;
            nxt_hi  = phi_q;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (load) begin
                    div_d    = div_in;
                    hi_d     = high_cnt;
                    pend_v_d = 1'b0;
                end
                if (en) begin
                    state_d = RUN;
                    clk_d   = (load ? high_cnt : hi_q) != '0;
                end
            end
            default: begin
                if (restart) begin
                    div_d    = nxt_div;
                    hi_d     = nxt_hi;
                    pend_v_d = 1'b0;
                    cnt_d    = '0;
                    if (boundary && !en) begin
                        state_d = IDLE;
                        clk_d   = 1'b0;
                    end else begin
                        state_d = en ? RUN : STOPPING;
                        clk_d   = nxt_hi != '0;
                    end
                end else begin
                    if (load) begin
                        pdiv_d   = div_in;
                        phi_d    = high_cnt;
                        pend_v_d = 1'b1;
                    end
                    state_d = en ? RUN : STOPPING;
                    cnt_d   = cnt_inc;
                    clk_d   = cnt_inc < hi_q;
                    tick_d  = cnt_inc == div_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= W'(DIV_RST);
            hi_q     <= W'(HI_RST);
            pdiv_q   <= W'(DIV_RST);
            phi_q    <= W'(HI_RST);
            pend_v_q <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            hi_q     <= hi_d;
            pdiv_q   <= pdiv_d;
            phi_q    <= phi_d;
            pend_v_q <= pend_v_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    assign clkout = clk_q;
    assign tick   = tick_q;
    assign busy   = state_q != IDLE;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider; channels share only clkin, reset and sync.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int CH = 2,
    parameter int W  = 16
) (
    input  logic            clkin,
    input  logic            reset,
    input  logic [CH-1:0]   en,
    input  logic [CH-1:0]   load,
    input  logic [CH*W-1:0] divisor,
    input  logic [CH*W-1:0] high_cnt,
    input  logic            sync,
    output logic [CH-1:0]   clkout,
    output logic [CH-1:0]   tick,
    output logic [CH-1:0]   busy
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        clk_div_chan #(.W(W)) u_chan (
            .clkin    (clkin),
            .reset    (reset),
            .en       (en[g]),
            .load     (load[g]),
            .sync     (sync),
            .divisor  (divisor[g*W +: W]),
            .high_cnt (high_cnt[g*W +: W]),
            .clkout   (clkout[g]),
            .tick     (tick[g]),
            .busy     (busy[g])
        );
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus random traffic against a phase-based model.
module tb_clk_div_prog;
    localparam int CH = 2;
    localparam int W  = 16;

    logic            clkin = 1'b0;
    logic            reset = 1'b1;
    logic            sync  = 1'b0;
    logic [CH-1:0]   en    = '0;
    logic [CH-1:0]   load  = '0;
    logic [CH*W-1:0] divisor  = '0;
    logic [CH*W-1:0] high_cnt = '0;
    logic [CH-1:0]   clkout, tick, busy;

    int checks = 0;
    int errors = 0;

    // Model: a running channel sits at phase ph of a period of length div.
    int m_busy[CH], m_ph[CH], m_div[CH], m_hi[CH];
    int m_pdiv[CH], m_phi[CH], m_pv[CH];

    clk_div_prog #(.CH(CH), .W(W)) dut (
        .clkin(clkin), .reset(reset), .en(en), .load(load),
        .divisor(divisor), .high_cnt(high_cnt), .sync(sync),
        .clkout(clkout), .tick(tick), .busy(busy)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_busy[i] = 0; m_ph[i] = 0; m_div[i] = 2; m_hi[i] = 1; m_pv[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < CH; i++) begin
            int d, h;
            bit bnd;
            d = int'(divisor[i*W +: W]);
            if (d < 2) d = 2;
            h = int'(high_cnt[i*W +: W]);
            if (m_busy[i] == 0) begin
                if (load[i]) begin m_div[i] = d; m_hi[i] = h; m_pv[i] = 0; end
                if (en[i]) begin m_busy[i] = 1; m_ph[i] = 0; end
            end else begin
                bnd = (m_ph[i] == m_div[i] - 1);
                if (bnd || sync) begin
                    if (load[i]) begin m_div[i] = d; m_hi[i] = h; end
                    else if (m_pv[i] != 0) begin m_div[i] = m_pdiv[i]; m_hi[i] = m_phi[i]; end
                    m_pv[i] = 0;
                    m_ph[i] = 0;
                    if (bnd && !en[i]) m_busy[i] = 0;
                end else begin
                    if (load[i]) begin m_pdiv[i] = d; m_phi[i] = h; m_pv[i] = 1; end
                    m_ph[i]++;
                end
            end
        end
    endtask

    function automatic int exp_clk(int i);
        return (m_busy[i] != 0 && m_ph[i] < m_hi[i]) ? 1 : 0;
    endfunction

    function automatic int exp_tick(int i);
        return (m_busy[i] != 0 && m_ph[i] == m_div[i] - 1) ? 1 : 0;
    endfunction

    task automatic compare_all();
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("clkout%0d", i), int'(clkout[i]), exp_clk(i));
            chk($sformatf("tick%0d", i),   int'(tick[i]),   exp_tick(i));
            chk($sformatf("busy%0d", i),   int'(busy[i]),   m_busy[i]);
        end
    endtask

    task automatic cyc();
        @(posedge clkin);
        model_step();
        @(negedge clkin);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic set_val(input int ch, input int d, input int h);
        divisor[ch*W +: W]  = W'(d);
        high_cnt[ch*W +: W] = W'(h);
    endtask

    task automatic cfg(input int ch, input int d, input int h);
        set_val(ch, d, h);
        load[ch] = 1'b1;
        cyc();
        load[ch] = 1'b0;
    endtask

    task automatic wait_ph(input int ch, input int ph, input string tag);
        for (int k = 0; k < 200 && !(m_busy[ch] != 0 && m_ph[ch] == ph); k++) cyc();
        chk(tag, m_ph[ch], ph);
    endtask

    task automatic wait_idle(input int ch, input string tag);
        for (int k = 0; k < 200 && m_busy[ch] != 0; k++) cyc();
        chk(tag, int'(busy[ch]), 0);
    endtask

    initial begin
        model_reset();
        @(negedge clkin);
        @(negedge clkin);
        compare_all();
        reset = 1'b0;

        // Basic ratios from idle, including odd divisor.
        cfg(0, 10, 5);
        cfg(1, 7, 3);
        en = 2'b11;
        run(40);

        // Divisor 1 clamps to 2 via pending path.
        cfg(1, 1, 1);
        run(20);

        // Mid-period reload; two loads, last wins.
        wait_ph(0, 3, "wait_ch0_cnt3");
        cfg(0, 4, 2);
        run(12);
        wait_ph(0, 1, "wait_ch0_cnt1");
        cfg(0, 6, 1);
        cfg(0, 4, 2);
        run(12);

        // Stop mid-period, re-raise during STOPPING, then stop cleanly.
        cfg(0, 8, 4);
        wait_ph(0, 0, "wait_ch0_new_period");
        wait_ph(0, 2, "wait_ch0_cnt2");
        en[0] = 1'b0;
        run(2);
        en[0] = 1'b1;
        run(10);
        wait_ph(0, 2, "wait_ch0_cnt2b");
        en[0] = 1'b0;
        wait_idle(0, "ch0_idle_after_stop");
        chk("ch0_clk_after_stop", int'(clkout[0]), 0);

        // Sync aligns staggered channels.
        en[1] = 1'b0;
        wait_idle(1, "ch1_idle");
        cfg(0, 6, 3);
        cfg(1, 9, 4);
        en[0] = 1'b1;
        run(3);
        en[1] = 1'b1;
        run(4);
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        chk("sync_clkout", int'(clkout), 3);
        chk("sync_tick", int'(tick), 0);
        run(20);

        // Asynchronous reset while clkout is high.
        for (int k = 0; k < 50 && exp_clk(0) == 0; k++) cyc();
        chk("pre_reset_clk0", int'(clkout[0]), 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_clkout", int'(clkout), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 0);
        model_reset();
        @(negedge clkin);
        reset = 1'b0;
        run(10);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 19) == 0) en[i] = ~en[i];
                load[i] = ($urandom_range(0, 7) == 0);
                set_val(i, $urandom_range(0, 12), $urandom_range(0, 14));
            end
            sync = ($urandom_range(0, 29) == 0);
            cyc();
        end
        load = '0;
        sync = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Parametrised multi-channel programmable clock divider, the successor to the single-channel even/odd dividers. Each channel divides `clkin` by a runtime divisor (even or odd) with a programmable high time. Divisor and duty-cycle updates are glitch-free. Channels start and stop cleanly on period boundaries and can be phase-aligned by a common sync pulse. Outputs feed downstream sampling logic as divided clock-enables/clocks plus one-cycle period strobes.

## Interface
- `CH`, default 2: number of independent channels.
- `W`, default 16: width of divisor and high-count fields.
- `clkin` input 1: single clock; every register is on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `en` input CH: per-channel run request, level-sensitive.
- `load` input CH: per-channel one-cycle pulse that captures `divisor`/`high_cnt` for that channel.
- `divisor` input CH*W: channel i in bits [i*W +: W]; period in `clkin` cycles.
- `high_cnt` input CH*W: channel i in bits [i*W +: W]; `clkout` high cycles per period.
- `sync` input 1: one-cycle pulse that restarts all running channels at phase 0.
- `clkout` output CH: registered divided clock per channel.
- `tick` output CH: registered one-cycle strobe in the last cycle of each period.
- `busy` output CH: 1 while the channel is in RUN or STOPPING.

## Operation
- Per-channel state machine:
  - IDLE: cnt=0, `clkout`=0, `tick`=0.
  - IDLE→RUN when `en`=1. cnt←0, `clkout`←(hi_q>0).
  - RUN→STOPPING when `en`=0. Counting continues.
  - STOPPING→RUN when `en`=1 again, with no disturbance to the waveform.
  - STOPPING→IDLE at the period boundary.
- Counter: cnt runs 0..div_q-1 and wraps to 0. The boundary is the cycle with cnt==div_q-1.
- `clkout` = (next cnt < hi_q), registered.
  - hi_q=0 → `clkout` stuck low.
  - hi_q≥div_q → `clkout` stuck high.
- `tick`=1 in the cycle cnt==div_q-1, in RUN or STOPPING. Never asserted in IDLE.
- Divisor clamp: `divisor` values 0 or 1 are captured as 2 (DIV_MIN).
- Load rules:
  - In IDLE, `load` writes div_q/hi_q directly.
  - In RUN or STOPPING, `load` writes a pending register and sets pend_v. Pending values apply at the next boundary or sync.
  - Several loads before a boundary: the last one wins.
  - `load` in the boundary cycle: the new values govern the period that starts next. They bypass pending.
- `sync` acts on every channel in RUN or STOPPING:
  - cnt←0 and pending values apply.
  - `clkout`←(hi>0).
  - `tick` is not asserted.
  - A STOPPING channel returns to IDLE only at a later natural boundary.
  - IDLE channels ignore `sync`.
- Sync priority: `sync` in the same cycle as a boundary behaves as a boundary, plus the STOPPING→IDLE exit.

## Timing
- Reset values:
  - All outputs 0, state IDLE, cnt=0.
  - div_q=2, hi_q=1, pend_v=0.
- Start latency: `en` sampled high at edge t → `clkout`=1 after edge t (for hi_q≥1). The first period is exactly div_q cycles.
- Waveform: period = div_q cycles, high = min(hi_q, div_q) cycles. Odd divisors give duty hi_q/div_q. Duty is exactly 50% only when requested.
- Stop: `en` low mid-period → the current period completes. `clkout` is 0 and `busy` is 0 after the boundary edge. No runt pulses.
- Reset mid-operation: outputs go to 0 immediately (asynchronous). After reset is released, the channel restarts from the reset divisor defaults.
- Channels are fully independent apart from the shared `sync`.

## Structure
- Shared package `clk_div_pkg` holds:
  - the state enum (IDLE, RUN, STOPPING);
  - DIV_MIN=2;
  - reset defaults DIV_RST=2 and HI_RST=1.
- Sub-module `clk_div_chan` holds one channel: state machine, counter, shadow and pending registers.
- The top level instantiates `clk_div_chan` CH times in a generate loop and slices the buses.

## Test plan
- Channel 0: load divisor=10, high_cnt=5, then en=1 → `clkout` is 5 high / 5 low repeating, and `tick` pulses every 10 cycles in cnt=9.
- Channel 1: divisor=7, high_cnt=3 → 3 high / 4 low. Divisor=1 → behaves as 2 (1 high / 1 low).
- While running with divisor=10, load divisor=4/high_cnt=2 at cnt=3 → the current period completes with 10 cycles, then 4-cycle periods follow. Two loads before the boundary → only the last takes effect.
- Drop en at cnt=2 with divisor=8/high_cnt=4 → the period finishes, `clkout` goes low after the boundary, `busy` falls, no runt pulse. Re-raise en during STOPPING → waveform continues unbroken.
- Channels at divisors 6 and 9 with staggered starts, pulse sync → both show cnt=0 and `clkout`=1 on the next cycle, with no `tick` from the sync.
- Assert reset mid-high → `clkout`, `tick` and `busy` are 0 immediately. After release, en=1 runs at the defaults (period 2, 1 high).
